// File: rtl/writeback_arbiter_pkg.sv
// Shared CPU constants and types for the register-file writeback path.
package writeback_arbiter_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] rd;
    logic [CPU_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Pipeline writeback, MC result handshake and register-file write port bundle.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
);
  logic              wb_valid;
  logic              wb_sel;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] alu_result;
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_rd;
  logic [DATA_W-1:0] mc_data;
  logic              stall_pipe;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;

  modport master (
    output wb_valid, wb_sel, wb_rd, mem_data, alu_result,
    output mc_valid, mc_rd, mc_data,
    input  mc_ready, stall_pipe, rf_we, rf_addr, rf_wdata, busy
  );

  modport slave (
    input  wb_valid, wb_sel, wb_rd, mem_data, alu_result,
    input  mc_valid, mc_rd, mc_data,
    output mc_ready, stall_pipe, rf_we, rf_addr, rf_wdata, busy
  );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Small power-of-two FIFO buffering MC results; full/empty come from a registered count.
module wb_result_fifo #(
  parameter  int WIDTH = 20,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered MC results, forcing a one-cycle pipeline stall when the MC head starves.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_W       = CPU_DATA_W,
  parameter int ADDR_W       = CPU_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  writeback_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wb_state_t                r_state;
  wb_state_t                w_state_nxt;
  logic [STV_W-1:0]         r_starve;
  logic [STV_W-1:0]         w_starve_nxt;
  logic                     w_full;
  logic                     w_empty;
  logic [CNT_W-1:0]         w_count;
  logic [CNT_W-1:0]         w_count_nxt;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic                     w_grant_wb;
  logic                     w_grant_head;
  logic                     w_grant_byp;
  logic                     w_enq;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        w_data;
  logic                     r_rf_we;
  logic [ADDR_W-1:0]        r_rf_addr;
  logic [DATA_W-1:0]        r_rf_wdata;

  wb_result_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_enq),
    .i_din   ({bus.mc_rd, bus.mc_data}),
    .i_pop   (w_grant_head),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Grant selection: forced head, then pipeline, then head, then MC bypass.
  always_comb begin
    w_grant_wb   = 1'b0;
    w_grant_head = 1'b0;
    w_grant_byp  = 1'b0;
    w_addr       = '0;
    w_data       = '0;
    if (r_state == FORCE) begin
      w_grant_head = 1'b1;
      {w_addr, w_data} = w_head;
    end else if (bus.wb_valid) begin
      w_grant_wb = 1'b1;
      w_addr     = bus.wb_rd;
      w_data     = bus.wb_sel ? bus.alu_result : bus.mem_data;
    end else if (!w_empty) begin
      w_grant_head = 1'b1;
      {w_addr, w_data} = w_head;
    end else if (bus.mc_valid) begin
      w_grant_byp = 1'b1;
      w_addr      = bus.mc_rd;
      w_data      = bus.mc_data;
    end else begin
      w_grant_wb = 1'b0;
    end
  end

  assign w_enq = bus.mc_valid && !w_full && !w_grant_byp;

  // Starvation counter and next-state logic from the projected FIFO occupancy.
  always_comb begin
    w_starve_nxt = r_starve;
    w_count_nxt  = w_count;
    w_state_nxt  = r_state;
    if (w_empty || w_grant_head) begin
      w_starve_nxt = '0;
    end else if (r_starve != STV_W'(STARVE_LIMIT)) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end else begin
      w_starve_nxt = r_starve;
    end
    if (w_enq && !w_grant_head) begin
      w_count_nxt = w_count + CNT_W'(1);
    end else if (!w_enq && w_grant_head) begin
      w_count_nxt = w_count - CNT_W'(1);
    end else begin
      w_count_nxt = w_count;
    end
    case (r_state)
      FORCE: w_state_nxt = (w_count_nxt != '0) ? PEND : IDLE;
      default: begin
        if ((r_starve == STV_W'(STARVE_LIMIT)) && bus.wb_valid) begin
          w_state_nxt = FORCE;
        end else begin
          w_state_nxt = (w_count_nxt != '0) ? PEND : IDLE;
        end
      end
    endcase
  end

  // State, starvation counter and registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_rf_we  <= w_grant_wb || w_grant_head || w_grant_byp;
      if (w_grant_wb || w_grant_head || w_grant_byp) begin
        r_rf_addr  <= w_addr;
        r_rf_wdata <= w_data;
      end else begin
        r_rf_addr  <= r_rf_addr;
        r_rf_wdata <= r_rf_wdata;
      end
    end
  end

  assign bus.mc_ready   = !w_full;
  assign bus.busy       = !w_empty;
  assign bus.stall_pipe = (r_state == FORCE);
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.rf_wdata   = r_rf_wdata;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed table-driven bench for writeback_arbiter plus starvation and reset sequences.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  writeback_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  writeback_arbiter #(
    .DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        wv;
    logic        ws;
    logic [3:0]  wr;
    logic [15:0] md;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  mr;
    logic [15:0] mdat;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic        e_busy;
    logic        e_rdy;
    logic        e_stall;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic wv, input logic ws, input logic [3:0] wr,
                              input logic [15:0] md, input logic [15:0] ad,
                              input logic mv, input logic [3:0] mr, input logic [15:0] mdat,
                              input logic e_we, input logic [3:0] e_addr, input logic [15:0] e_data,
                              input logic e_busy, input logic e_rdy, input logic e_stall);
    vec_t v;
    v = '{wv, ws, wr, md, ad, mv, mr, mdat, e_we, e_addr, e_data, e_busy, e_rdy, e_stall};
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  task automatic check_out(input int tag, input logic we, input logic [3:0] a, input logic [15:0] d,
                           input logic bsy, input logic rdy, input logic stl);
    chk("rf_we", tag, 32'(bus.rf_we), 32'(we));
    if (we) begin
      chk("rf_addr", tag, 32'(bus.rf_addr), 32'(a));
      chk("rf_wdata", tag, 32'(bus.rf_wdata), 32'(d));
    end
    chk("busy", tag, 32'(bus.busy), 32'(bsy));
    chk("mc_ready", tag, 32'(bus.mc_ready), 32'(rdy));
    chk("stall_pipe", tag, 32'(bus.stall_pipe), 32'(stl));
  endtask

  task automatic drive(input logic wv, input logic ws, input logic [3:0] wr,
                       input logic [15:0] md, input logic [15:0] ad,
                       input logic mv, input logic [3:0] mr, input logic [15:0] mdat);
    @(negedge clk);
    bus.wb_valid   = wv;
    bus.wb_sel     = ws;
    bus.wb_rd      = wr;
    bus.mem_data   = md;
    bus.alu_result = ad;
    bus.mc_valid   = mv;
    bus.mc_rd      = mr;
    bus.mc_data    = mdat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wb_valid = 1'b0; bus.wb_sel = 1'b0; bus.wb_rd = 4'd0;
    bus.mem_data = 16'h0; bus.alu_result = 16'h0;
    bus.mc_valid = 1'b0; bus.mc_rd = 4'd0; bus.mc_data = 16'h0;

    // Pipeline, bypass, contention, full FIFO and r0 write, applied back to back.
    vecs[0]  = mk(1'b1,1'b0,4'd3,16'h00FF,16'h1111, 1'b0,4'd0,16'h0000, 1'b1,4'd3,16'h00FF, 1'b0,1'b1,1'b0);
    vecs[1]  = mk(1'b1,1'b1,4'd3,16'h2222,16'hFF00, 1'b0,4'd0,16'h0000, 1'b1,4'd3,16'hFF00, 1'b0,1'b1,1'b0);
    vecs[2]  = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,1'b1,1'b0);
    vecs[3]  = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b1,4'd5,16'hAAAA, 1'b1,4'd5,16'hAAAA, 1'b0,1'b1,1'b0);
    vecs[4]  = mk(1'b1,1'b1,4'd2,16'h0000,16'h5555, 1'b1,4'd7,16'h1234, 1'b1,4'd2,16'h5555, 1'b1,1'b1,1'b0);
    vecs[5]  = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd7,16'h1234, 1'b0,1'b1,1'b0);
    vecs[6]  = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,1'b1,1'b0);
    vecs[7]  = mk(1'b1,1'b1,4'd1,16'h0000,16'h0101, 1'b1,4'd8,16'h8888, 1'b1,4'd1,16'h0101, 1'b1,1'b1,1'b0);
    vecs[8]  = mk(1'b1,1'b1,4'd1,16'h0000,16'h0102, 1'b1,4'd9,16'h9999, 1'b1,4'd1,16'h0102, 1'b1,1'b0,1'b0);
    vecs[9]  = mk(1'b1,1'b1,4'd1,16'h0000,16'h0103, 1'b1,4'd10,16'hAAAB, 1'b1,4'd1,16'h0103, 1'b1,1'b0,1'b0);
    vecs[10] = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b1,4'd10,16'hAAAB, 1'b1,4'd8,16'h8888, 1'b1,1'b1,1'b0);
    vecs[11] = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b1,4'd10,16'hAAAB, 1'b1,4'd9,16'h9999, 1'b1,1'b1,1'b0);
    vecs[12] = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd10,16'hAAAB, 1'b0,1'b1,1'b0);
    vecs[13] = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,1'b1,1'b0);
    vecs[14] = mk(1'b1,1'b0,4'd0,16'hBEEF,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd0,16'hBEEF, 1'b0,1'b1,1'b0);
    vecs[15] = mk(1'b0,1'b0,4'd0,16'h0000,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,1'b1,1'b0);

    #1;
    chk("reset_rf_we", 0, 32'(bus.rf_we), 32'd0);
    chk("reset_rf_addr", 0, 32'(bus.rf_addr), 32'd0);
    chk("reset_rf_wdata", 0, 32'(bus.rf_wdata), 32'd0);
    chk("reset_busy", 0, 32'(bus.busy), 32'd0);
    chk("reset_mc_ready", 0, 32'(bus.mc_ready), 32'd1);
    chk("reset_stall", 0, 32'(bus.stall_pipe), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wv, vecs[i].ws, vecs[i].wr, vecs[i].md, vecs[i].ad,
            vecs[i].mv, vecs[i].mr, vecs[i].mdat);
      step();
      check_out(i, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                vecs[i].e_busy, vecs[i].e_rdy, vecs[i].e_stall);
    end

    // Starvation: pipeline writes every cycle while one MC entry waits at the head.
    drive(1'b1, 1'b0, 4'd4, 16'h4000, 16'h0, 1'b1, 4'd6, 16'h6666);
    step();
    stall_cnt += int'(bus.stall_pipe);
    check_out(100, 1'b1, 4'd4, 16'h4000, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 4'd4, 16'h4000 + 16'(k), 16'h0, 1'b0, 4'd0, 16'h0);
      step();
      stall_cnt += int'(bus.stall_pipe);
      check_out(100 + k, 1'b1, 4'd4, 16'h4000 + 16'(k), 1'b1, 1'b1, (k == 5));
    end
    drive(1'b1, 1'b0, 4'd4, 16'h4006, 16'h0, 1'b0, 4'd0, 16'h0);
    step();
    stall_cnt += int'(bus.stall_pipe);
    check_out(106, 1'b1, 4'd6, 16'h6666, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'd4, 16'h4006, 16'h0, 1'b0, 4'd0, 16'h0);
    step();
    stall_cnt += int'(bus.stall_pipe);
    check_out(107, 1'b1, 4'd4, 16'h4006, 1'b0, 1'b1, 1'b0);
    chk("stall_once", 108, 32'(stall_cnt), 32'd1);

    // Reset mid-operation with the FIFO full.
    drive(1'b1, 1'b1, 4'd1, 16'h0, 16'h0201, 1'b1, 4'd11, 16'hBBBB);
    step();
    drive(1'b1, 1'b1, 4'd1, 16'h0, 16'h0202, 1'b1, 4'd12, 16'hCCCC);
    step();
    check_out(200, 1'b1, 4'd1, 16'h0202, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'd1, 16'h0, 16'h0203, 1'b0, 4'd0, 16'h0);
    @(posedge clk);
    #2;
    chk("pre_reset_we", 201, 32'(bus.rf_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_rf_we", 202, 32'(bus.rf_we), 32'd0);
    chk("midrst_busy", 202, 32'(bus.busy), 32'd0);
    chk("midrst_mc_ready", 202, 32'(bus.mc_ready), 32'd1);
    chk("midrst_stall", 202, 32'(bus.stall_pipe), 32'd0);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 16'h0);
      step();
      check_out(210 + j, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
